// File: rtl/branch_cond_unit.sv
// Branch condition unit: resolves B / B.cond / CBZ against the (optionally forwarded) flags,
// registers the taken decision and sequences the wrong-path flush. Stats counters: BRANCH_STATS_EN.
module branch_cond_unit #(
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             br_uncond,
  input  logic             br_cbz,
  input  logic             br_cond,
  input  logic [3:0]       cond,
  input  logic [2:0]       flag_q,
  input  logic             z_q,
  input  logic             fwd_valid,
  input  logic [2:0]       fwd_nvc,
  input  logic             fwd_z,
  input  logic             alu_zero,
  input  logic             stall,
  output logic             taken,
  output logic             flush,
  output logic             busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
`endif
);

  localparam int unsigned DEPTH = (FLUSH_DEPTH < 1) ? 1 :
                                  (FLUSH_DEPTH > 3) ? 3 : FLUSH_DEPTH;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t     r_state, w_state_n;
  logic [1:0] r_cnt, w_cnt_n;
  logic       r_taken, w_taken_n;
  logic       r_flush, w_flush_n;
  logic       r_busy, w_busy_n;

  logic w_n, w_v, w_c, w_z;
  logic w_ge, w_gt, w_hi;
  logic w_cond_true;
  logic w_take;
  logic w_br_present;
  logic w_resolve;

  // EX result overrides the flag register when it is writing the flags this cycle
  assign {w_n, w_v, w_c} = fwd_valid ? fwd_nvc : flag_q;
  assign w_z             = fwd_valid ? fwd_z   : z_q;

  assign w_ge = (w_n == w_v);
  assign w_gt = ~w_z & w_ge;
  assign w_hi = w_c & ~w_z;

  always_comb begin
    w_cond_true = 1'b0;
    unique case (cond)
      4'b0000: w_cond_true = w_z;
      4'b0001: w_cond_true = ~w_z;
      4'b0010: w_cond_true = w_c;
      4'b0011: w_cond_true = ~w_c;
      4'b0100: w_cond_true = w_n;
      4'b0101: w_cond_true = ~w_n;
      4'b0110: w_cond_true = w_v;
      4'b0111: w_cond_true = ~w_v;
      4'b1000: w_cond_true = w_hi;
      4'b1001: w_cond_true = ~w_hi;
      4'b1010: w_cond_true = w_ge;
      4'b1011: w_cond_true = ~w_ge;
      4'b1100: w_cond_true = w_gt;
      4'b1101: w_cond_true = ~w_gt;
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_br_present = valid_in & (br_uncond | br_cbz | br_cond);

  always_comb begin
    if (br_uncond)   w_take = 1'b1;
    else if (br_cbz) w_take = alu_zero;
    else             w_take = w_cond_true;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_taken_n = 1'b0;
    w_flush_n = 1'b0;
    w_busy_n  = 1'b0;
    w_resolve = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // While flush is up the slot behind the taken branch is wrong-path, even at DEPTH=1
        if (w_br_present && !r_flush) begin
          w_resolve = 1'b1;
          if (w_take) begin
            w_taken_n = 1'b1;
            w_flush_n = 1'b1;
            w_cnt_n   = 2'(DEPTH - 1);
            if (DEPTH > 1) w_state_n = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n   = r_cnt - 2'd1;
          w_flush_n = 1'b1;
          w_busy_n  = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_taken <= 1'b0;
      r_flush <= 1'b0;
      r_busy  <= 1'b0;
    end else if (!stall) begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_taken <= w_taken_n;
      r_flush <= w_flush_n;
      r_busy  <= w_busy_n;
    end
  end

  assign taken = r_taken;
  assign flush = r_flush;
  assign busy  = r_busy;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_ntaken_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_cnt  <= '0;
      r_ntaken_cnt <= '0;
    end else if (!stall && w_resolve) begin
      if (w_take) r_taken_cnt  <= r_taken_cnt + CNT_W'(1);
      else        r_ntaken_cnt <= r_ntaken_cnt + CNT_W'(1);
    end
  end

  assign taken_cnt  = r_taken_cnt;
  assign ntaken_cnt = r_ntaken_cnt;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: a FLUSH_DEPTH=1 and a FLUSH_DEPTH=3 instance on shared stimulus.
module tb_branch_cond_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, valid_in, br_uncond, br_cbz, br_cond;
  logic [3:0] cond;
  logic [2:0] flag_q, fwd_nvc;
  logic       z_q, fwd_valid, fwd_z, alu_zero, stall;
  logic       a_taken, a_flush, a_busy;
  logic       b_taken, b_flush, b_busy;
`ifdef BRANCH_STATS_EN
  logic [3:0] a_tcnt, a_ncnt, b_tcnt, b_ncnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  branch_cond_unit #(.FLUSH_DEPTH(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in), .br_uncond(br_uncond), .br_cbz(br_cbz),
    .br_cond(br_cond), .cond(cond), .flag_q(flag_q), .z_q(z_q), .fwd_valid(fwd_valid),
    .fwd_nvc(fwd_nvc), .fwd_z(fwd_z), .alu_zero(alu_zero), .stall(stall),
    .taken(a_taken), .flush(a_flush), .busy(a_busy)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(a_tcnt), .ntaken_cnt(a_ncnt)
`endif
  );

  branch_cond_unit #(.FLUSH_DEPTH(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_in), .br_uncond(br_uncond), .br_cbz(br_cbz),
    .br_cond(br_cond), .cond(cond), .flag_q(flag_q), .z_q(z_q), .fwd_valid(fwd_valid),
    .fwd_nvc(fwd_nvc), .fwd_z(fwd_z), .alu_zero(alu_zero), .stall(stall),
    .taken(b_taken), .flush(b_flush), .busy(b_busy)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(b_tcnt), .ntaken_cnt(b_ncnt)
`endif
  );

  // {cond, {N,V,C}, Z, expected taken}
  localparam int NV = 40;
  logic [8:0] cvec [0:NV-1] = '{
    {4'h0,3'b000,1'b1,1'b1}, {4'h0,3'b000,1'b0,1'b0},
    {4'h1,3'b000,1'b0,1'b1}, {4'h1,3'b000,1'b1,1'b0},
    {4'h2,3'b001,1'b0,1'b1}, {4'h2,3'b000,1'b0,1'b0},
    {4'h3,3'b000,1'b0,1'b1}, {4'h3,3'b001,1'b0,1'b0},
    {4'h4,3'b100,1'b0,1'b1}, {4'h4,3'b000,1'b0,1'b0},
    {4'h5,3'b000,1'b0,1'b1}, {4'h5,3'b100,1'b0,1'b0},
    {4'h6,3'b010,1'b0,1'b1}, {4'h6,3'b000,1'b0,1'b0},
    {4'h7,3'b000,1'b0,1'b1}, {4'h7,3'b010,1'b0,1'b0},
    {4'h8,3'b001,1'b0,1'b1}, {4'h8,3'b001,1'b1,1'b0}, {4'h8,3'b000,1'b0,1'b0},
    {4'h9,3'b001,1'b1,1'b1}, {4'h9,3'b001,1'b0,1'b0}, {4'h9,3'b000,1'b0,1'b1},
    {4'hA,3'b110,1'b0,1'b1}, {4'hA,3'b100,1'b0,1'b0}, {4'hA,3'b000,1'b0,1'b1}, {4'hA,3'b010,1'b0,1'b0},
    {4'hB,3'b100,1'b0,1'b1}, {4'hB,3'b110,1'b0,1'b0}, {4'hB,3'b010,1'b0,1'b1}, {4'hB,3'b000,1'b0,1'b0},
    {4'hC,3'b000,1'b0,1'b1}, {4'hC,3'b000,1'b1,1'b0}, {4'hC,3'b100,1'b0,1'b0}, {4'hC,3'b110,1'b0,1'b1},
    {4'hD,3'b000,1'b1,1'b1}, {4'hD,3'b000,1'b0,1'b0}, {4'hD,3'b010,1'b0,1'b1}, {4'hD,3'b110,1'b0,1'b0},
    {4'hE,3'b000,1'b0,1'b1}, {4'hF,3'b111,1'b1,1'b1}
  };

  // {valid_in, br_uncond, br_cbz, br_cond, alu_zero, cond, expected taken}; flags all zero
  localparam int NP = 7;
  logic [9:0] pvec [0:NP-1] = '{
    {1'b1,1'b1,1'b1,1'b0,1'b0,4'h0,1'b1},
    {1'b1,1'b0,1'b1,1'b1,1'b1,4'h0,1'b1},
    {1'b1,1'b0,1'b1,1'b1,1'b0,4'hE,1'b0},
    {1'b1,1'b0,1'b0,1'b0,1'b1,4'hE,1'b0},
    {1'b0,1'b1,1'b0,1'b0,1'b0,4'hE,1'b0},
    {1'b1,1'b0,1'b1,1'b0,1'b1,4'h1,1'b1},
    {1'b1,1'b0,1'b1,1'b0,1'b0,4'hE,1'b0}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    valid_in  = 1'b0;
    br_uncond = 1'b0;
    br_cbz    = 1'b0;
    br_cond   = 1'b0;
  endtask

  task automatic issue_b();
    valid_in  = 1'b1;
    br_uncond = 1'b1;
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  initial begin
    logic [8:0] e;
    logic [9:0] pv;
    logic [2:0] nvc;
    logic       zz, ex;

    reset = 1'b1; stall = 1'b0; clear_br();
    cond = 4'h0; flag_q = 3'b000; z_q = 1'b0;
    fwd_valid = 1'b0; fwd_nvc = 3'b000; fwd_z = 1'b0; alu_zero = 1'b0;
    step(); step();
    check("rst_a_taken", a_taken, 0); check("rst_a_flush", a_flush, 0); check("rst_a_busy", a_busy, 0);
    check("rst_b_taken", b_taken, 0); check("rst_b_flush", b_flush, 0); check("rst_b_busy", b_busy, 0);
    reset = 1'b0;
    step();

    // condition-code sweep: pass 0 through the flag register, pass 1 through forwarding
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NV; i++) begin
        e = cvec[i];
        nvc = e[4:2]; zz = e[1]; ex = e[0];
        cond = e[8:5];
        if (p == 0) begin
          fwd_valid = 1'b0; flag_q = nvc; z_q = zz; fwd_nvc = ~nvc; fwd_z = ~zz;
        end else begin
          fwd_valid = 1'b1; fwd_nvc = nvc; fwd_z = zz; flag_q = ~nvc; z_q = ~zz;
        end
        valid_in = 1'b1; br_cond = 1'b1;
        step(); clear_br();
        check($sformatf("cc%0d_p%0d_a_taken", i, p), a_taken, ex);
        check($sformatf("cc%0d_p%0d_b_taken", i, p), b_taken, ex);
        check($sformatf("cc%0d_p%0d_a_flush", i, p), a_flush, ex);
        drain();
      end
    end
    fwd_valid = 1'b0; flag_q = 3'b000; z_q = 1'b0; fwd_nvc = 3'b000; fwd_z = 1'b0;

    // branch-type priority and CBZ
    for (int i = 0; i < NP; i++) begin
      pv = pvec[i];
      {valid_in, br_uncond, br_cbz, br_cond, alu_zero} = pv[9:5];
      cond = pv[4:1];
      step(); clear_br(); alu_zero = 1'b0;
      check($sformatf("prio%0d_a_taken", i), a_taken, pv[0]);
      check($sformatf("prio%0d_b_flush", i), b_flush, pv[0]);
      drain();
    end

    // LT taken on stored flags, depth 1: single-cycle flush, never busy
    cond = 4'hB; flag_q = 3'b100; fwd_valid = 1'b0;
    valid_in = 1'b1; br_cond = 1'b1;
    step(); clear_br();
    check("lt_a_taken", a_taken, 1); check("lt_a_flush", a_flush, 1); check("lt_a_busy", a_busy, 0);
    step();
    check("lt_a_taken2", a_taken, 0); check("lt_a_flush2", a_flush, 0); check("lt_a_busy2", a_busy, 0);
    drain();

    // EQ: forwarded Z wins over stored Z
    cond = 4'h0; flag_q = 3'b000; z_q = 1'b0; fwd_valid = 1'b1; fwd_nvc = 3'b000; fwd_z = 1'b1;
    valid_in = 1'b1; br_cond = 1'b1;
    step(); clear_br();
    check("eq_fwd_taken", a_taken, 1);
    drain();
    fwd_valid = 1'b0;
    valid_in = 1'b1; br_cond = 1'b1;
    step(); clear_br();
    check("eq_nofwd_taken", a_taken, 0);
    drain();
    fwd_z = 1'b0;

    // depth 3: B then two wrong-path CBZs that must be ignored
    issue_b();
    step(); clear_br();
    valid_in = 1'b1; br_cbz = 1'b1; alu_zero = 1'b1;
    check("d3_c1_taken", b_taken, 1); check("d3_c1_flush", b_flush, 1); check("d3_c1_busy", b_busy, 0);
    step();
    check("d3_c2_taken", b_taken, 0); check("d3_c2_flush", b_flush, 1); check("d3_c2_busy", b_busy, 1);
    step(); clear_br(); alu_zero = 1'b0;
    check("d3_c3_taken", b_taken, 0); check("d3_c3_flush", b_flush, 1); check("d3_c3_busy", b_busy, 1);
    step();
    check("d3_c4_taken", b_taken, 0); check("d3_c4_flush", b_flush, 0); check("d3_c4_busy", b_busy, 0);
    drain();

    // depth 3: two stalled cycles inside FLUSH stretch the flush window
    issue_b();
    step(); clear_br();
    check("st_c1_flush", b_flush, 1);
    step();
    check("st_c2_busy", b_busy, 1);
    stall = 1'b1;
    step();
    check("st_c3_flush", b_flush, 1); check("st_c3_busy", b_busy, 1);
    step();
    check("st_c4_flush", b_flush, 1); check("st_c4_busy", b_busy, 1);
    stall = 1'b0;
    step();
    check("st_c5_flush", b_flush, 1);
    step();
    check("st_c6_flush", b_flush, 0); check("st_c6_busy", b_busy, 0);
    drain();

    // stall holds the taken pulse
    issue_b();
    step(); clear_br();
    stall = 1'b1;
    step();
    check("hold_a_taken", a_taken, 1); check("hold_a_flush", a_flush, 1); check("hold_b_taken", b_taken, 1);
    stall = 1'b0;
    step();
    check("hold_a_taken2", a_taken, 0); check("hold_a_flush2", a_flush, 0);
    check("hold_b_taken2", b_taken, 0); check("hold_b_flush2", b_flush, 1);
    drain();

    // branch presented under stall resolves on the first unstalled edge
    stall = 1'b1; issue_b();
    step();
    check("brstall_a_taken0", a_taken, 0);
    stall = 1'b0;
    step(); clear_br();
    check("brstall_a_taken1", a_taken, 1);
    drain();

    // reset in the first FLUSH cycle wins over stall and a pending branch
    issue_b();
    step();
    reset = 1'b1; stall = 1'b1;
    step(); clear_br();
    reset = 1'b0; stall = 1'b0;
    check("rstfl_b_taken", b_taken, 0); check("rstfl_b_flush", b_flush, 0); check("rstfl_b_busy", b_busy, 0);
    check("rstfl_a_flush", a_flush, 0);
    step();
    check("rstfl_b_flush2", b_flush, 0);
    issue_b();
    step(); clear_br();
    check("rstfl_b_retaken", b_taken, 1); check("rstfl_b_rebusy0", b_busy, 0);
    step();
    check("rstfl_b_rebusy1", b_busy, 1);
    drain();

`ifdef BRANCH_STATS_EN
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("stat_rst_b_t", b_tcnt, 0); check("stat_rst_b_n", b_ncnt, 0);
    for (int i = 0; i < 16; i++) begin
      issue_b();
      step(); clear_br();
      drain();
      if (i == 4) check("stat_b_t5", b_tcnt, 5);
    end
    cond = 4'h0; z_q = 1'b0; fwd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; br_cond = 1'b1;
      step(); clear_br();
      drain();
    end
    check("stat_b_t", b_tcnt, 0); check("stat_b_n", b_ncnt, 2);
    check("stat_a_t", a_tcnt, 0); check("stat_a_n", a_ncnt, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
